// File: rtl/wb_writer.sv
// Register-file writeback arbiter: an in-order primary source with absolute priority,
// plus a small FIFO that buffers writes from a long-latency secondary source and
// drains them into idle writeback slots. All register-file outputs are registered.
module wb_writer #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [5:0]                  stall,
    input  logic                        mem_wreg,
    input  logic [4:0]                  mem_wd,
    input  logic [31:0]                 mem_wdata,
    input  logic                        sec_valid,
    input  logic [4:0]                  sec_wd,
    input  logic [31:0]                 sec_wdata,
    output logic                        sec_ready,
    output logic                        we,
    output logic [4:0]                  waddr,
    output logic [31:0]                 wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]      addr_mem_q [FIFO_DEPTH];
    logic [31:0]     data_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            sec_ready_q;
    logic            we_q, we_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic prim_acc;
    logic push;
    logic pop;

    // Only the writeback-stage stall bit matters here.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    assign prim_acc = ~stall[4] & mem_wreg & (mem_wd != 5'd0);
    // Writes to x0 complete the handshake but are dropped.
    assign push     = sec_valid & sec_ready_q & (sec_wd != 5'd0);
    // Pop depends on the registered count, so a fresh push is never popped the same cycle.
    assign pop      = ~prim_acc & (count_q != '0);

    // Select the next register-file write and the next buffer occupancy.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = 5'd0;
        wdata_d = 32'd0;
        if (prim_acc) begin
            we_d    = 1'b1;
            waddr_d = mem_wd;
            wdata_d = mem_wdata;
        end else if (pop) begin
            we_d    = 1'b1;
            waddr_d = addr_mem_q[rd_ptr_q];
            wdata_d = data_mem_q[rd_ptr_q];
        end

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // State update: outputs, FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sec_ready_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                addr_mem_q[i] <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            if (push) begin
                addr_mem_q[wr_ptr_q] <= sec_wd;
                data_mem_q[wr_ptr_q] <= sec_wdata;
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q     <= count_d;
            // Registered so there is no combinational path from sec_valid.
            sec_ready_q <= (count_d < CntW'(FIFO_DEPTH));
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign fifo_count = count_q;
    assign sec_ready  = sec_ready_q;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer with the default two-entry secondary buffer.
module tb_wb_writer;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        sec_valid;
    logic [4:0]  sec_wd;
    logic [31:0] sec_wdata;
    logic        sec_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_writer #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .sec_valid  (sec_valid),
        .sec_wd     (sec_wd),
        .sec_wdata  (sec_wdata),
        .sec_ready  (sec_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall     = 6'd0;
        mem_wreg  = 1'b0;
        mem_wd    = 5'd0;
        mem_wdata = 32'd0;
        sec_valid = 1'b0;
        sec_wd    = 5'd0;
        sec_wdata = 32'd0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        n_checks++;
        if ({we, waddr, wdata, fifo_count, sec_ready} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got we=%0b waddr=%0d wdata=%h cnt=%0d rdy=%0b want all 0",
                     we, waddr, wdata, fifo_count, sec_ready);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (sec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %0b want 1", sec_ready);
        end
        n_checks++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_we got %0b want 0", we);
        end
    endtask

    task automatic test_primary();
        mem_wreg  = 1'b1;
        mem_wd    = 5'd5;
        mem_wdata = 32'hDEADBEEF;
        step();
        idle_inputs();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL primary_write got we=%0b waddr=%0d wdata=%h want 1/5/deadbeef",
                     we, waddr, wdata);
        end
        step();
        n_checks++;
        if ({we, waddr, wdata} !== 38'd0) begin
            n_fail++;
            $display("FAIL primary_idle got we=%0b waddr=%0d wdata=%h want 0/0/0", we, waddr, wdata);
        end
    endtask

    task automatic test_bubbles();
        // Destination x0.
        mem_wreg  = 1'b1;
        mem_wd    = 5'd0;
        mem_wdata = 32'h12345678;
        step();
        n_checks++;
        if ({we, waddr, wdata} !== 38'd0) begin
            n_fail++;
            $display("FAIL bubble_x0 got we=%0b waddr=%0d wdata=%h want 0/0/0", we, waddr, wdata);
        end
        // Writeback stall.
        mem_wd = 5'd9;
        stall  = 6'b010000;
        step();
        n_checks++;
        if ({we, waddr, wdata} !== 38'd0) begin
            n_fail++;
            $display("FAIL bubble_stall got we=%0b waddr=%0d wdata=%h want 0/0/0", we, waddr, wdata);
        end
        // Other stall bits do not block.
        stall = 6'b101111;
        step();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd9, 32'h12345678}) begin
            n_fail++;
            $display("FAIL other_stall_bits got we=%0b waddr=%0d wdata=%h want 1/9/12345678",
                     we, waddr, wdata);
        end
        // No request.
        stall    = 6'd0;
        mem_wreg = 1'b0;
        step();
        idle_inputs();
        n_checks++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_nowreg got we=%0b want 0", we);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_a [8];
        logic [31:0] exp_d [8];
        logic [1:0]  exp_c [8];
        logic        exp_r [8];
        logic        exp_w [8];
        exp_a = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd0, 5'd0};
        exp_d = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h11, 32'h22, 32'h0, 32'h0};
        exp_c = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i < 4) begin
                mem_wreg  = 1'b1;
                mem_wd    = 5'(i + 1);
                mem_wdata = 32'hA0 + 32'(i + 1);
            end
            if (i == 0) begin
                sec_valid = 1'b1; sec_wd = 5'd7; sec_wdata = 32'h11;
            end else if (i == 1) begin
                sec_valid = 1'b1; sec_wd = 5'd8; sec_wdata = 32'h22;
            end
            step();
            n_checks++;
            if ({we, waddr, wdata, fifo_count, sec_ready} !==
                {exp_w[i], exp_a[i], exp_d[i], exp_c[i], exp_r[i]}) begin
                n_fail++;
                $display("FAIL burst_cycle%0d got we=%0b a=%0d d=%h c=%0d r=%0b want %0b/%0d/%h/%0d/%0b",
                         i, we, waddr, wdata, fifo_count, sec_ready,
                         exp_w[i], exp_a[i], exp_d[i], exp_c[i], exp_r[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_same_reg();
        mem_wreg = 1'b1; mem_wd = 5'd3; mem_wdata = 32'hA;
        sec_valid = 1'b1; sec_wd = 5'd3; sec_wdata = 32'hB;
        step();
        idle_inputs();
        n_checks++;
        if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'd3, 32'hA, 2'd1}) begin
            n_fail++;
            $display("FAIL same_reg_primary got we=%0b a=%0d d=%h c=%0d want 1/3/a/1",
                     we, waddr, wdata, fifo_count);
        end
        step();
        n_checks++;
        if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'd3, 32'hB, 2'd0}) begin
            n_fail++;
            $display("FAIL same_reg_secondary got we=%0b a=%0d d=%h c=%0d want 1/3/b/0",
                     we, waddr, wdata, fifo_count);
        end
        step();
        n_checks++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL same_reg_drained got we=%0b want 0", we);
        end
    endtask

    task automatic test_sec_x0();
        sec_valid = 1'b1; sec_wd = 5'd0; sec_wdata = 32'hFFFF;
        step();
        idle_inputs();
        n_checks++;
        if ({we, fifo_count, sec_ready} !== {1'b0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL sec_x0 got we=%0b c=%0d r=%0b want 0/0/1", we, fifo_count, sec_ready);
        end
        step();
        n_checks++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL sec_x0_nowrite got we=%0b want 0", we);
        end
    endtask

    task automatic test_push_pop();
        // Push into empty buffer: written two cycles later, while a second push overlaps the pop.
        sec_valid = 1'b1; sec_wd = 5'd10; sec_wdata = 32'h1010;
        step();
        n_checks++;
        if ({we, fifo_count} !== {1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL push_empty got we=%0b c=%0d want 0/1", we, fifo_count);
        end
        sec_wd = 5'd11; sec_wdata = 32'h1111;
        step();
        idle_inputs();
        n_checks++;
        if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'd10, 32'h1010, 2'd1}) begin
            n_fail++;
            $display("FAIL push_pop got we=%0b a=%0d d=%h c=%0d want 1/10/1010/1",
                     we, waddr, wdata, fifo_count);
        end
        step();
        n_checks++;
        if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'd11, 32'h1111, 2'd0}) begin
            n_fail++;
            $display("FAIL pop_order got we=%0b a=%0d d=%h c=%0d want 1/11/1111/0",
                     we, waddr, wdata, fifo_count);
        end
        // Stall does not block draining.
        sec_valid = 1'b1; sec_wd = 5'd12; sec_wdata = 32'h1212;
        step();
        idle_inputs();
        stall = 6'b010000;
        step();
        n_checks++;
        if ({we, waddr, wdata} !== {1'b1, 5'd12, 32'h1212}) begin
            n_fail++;
            $display("FAIL pop_under_stall got we=%0b a=%0d d=%h want 1/12/1212", we, waddr, wdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h5;
            sec_valid = 1'b1; sec_wd = 5'(20 + i); sec_wdata = 32'(i + 100);
            step();
        end
        n_checks++;
        if (fifo_count !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_reset_fill got c=%0d want 2", fifo_count);
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({we, waddr, wdata, fifo_count, sec_ready} !== 40'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async got we=%0b a=%0d d=%h c=%0d r=%0b want all 0",
                     we, waddr, wdata, fifo_count, sec_ready);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({we, fifo_count, sec_ready} !== {1'b0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL post_reset_cycle%0d got we=%0b c=%0d r=%0b want 0/0/1",
                         i, we, fifo_count, sec_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_bubbles();
        test_back_to_back();
        test_same_reg();
        test_sec_x0();
        test_push_pop();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of entries in the secondary-source write buffer (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 6, pipeline stall vector; only bit 4 (the writeback-stage stall) is used.
REQ-005 SHALL have port mem_wreg, input, 1, primary (in-order pipeline) write request.
REQ-006 SHALL have port mem_wd, input, 5, primary destination register.
REQ-007 SHALL have port mem_wdata, input, 32, primary write data.
REQ-008 SHALL have port sec_valid, input, 1, secondary (long-latency unit) write request.
REQ-009 SHALL have port sec_wd, input, 5, secondary destination register.
REQ-010 SHALL have port sec_wdata, input, 32, secondary write data.
REQ-011 SHALL have port sec_ready, output, 1, high when the secondary buffer can accept an entry.
REQ-012 SHALL have port we, output, 1, register-file write enable.
REQ-013 SHALL have port waddr, output, 5, register-file write address.
REQ-014 SHALL have port wdata, output, 32, register-file write data.
REQ-015 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1, number of buffered secondary entries.

Function
REQ-016 SHALL register we, waddr and wdata, giving one cycle of latency from an accepted request to the register-file write.
REQ-017 SHALL accept a primary request in cycle N when stall[4]=0, mem_wreg=1 and mem_wd!=0, and SHALL then drive we=1, waddr=mem_wd, wdata=mem_wdata in cycle N+1.
REQ-018 SHALL ignore the primary request (treat it as a bubble) when stall[4]=1, mem_wreg=0 or mem_wd=0.
REQ-019 SHALL give the primary source absolute priority; the primary source is never back-pressured.
REQ-020 SHALL complete a secondary handshake in a cycle where sec_valid=1 and sec_ready=1.
REQ-021 SHALL push a completed secondary handshake into the FIFO tail when sec_wd!=0.
REQ-022 SHALL consume a completed secondary handshake with sec_wd=0 without pushing it into the FIFO.
REQ-023 SHALL drive sec_ready from registered state only, as (fifo_count < FIFO_DEPTH); it SHALL have no combinational path from sec_valid.
REQ-024 SHALL pop the FIFO head in any cycle where no primary request is accepted and fifo_count>0, and SHALL drive that entry on we/waddr/wdata in the next cycle.
REQ-025 SHALL pop the FIFO regardless of stall[4]; stall[4] only blocks the primary source.
REQ-026 SHALL drive we=0 in the next cycle when neither a primary request is accepted nor the FIFO is non-empty; waddr and wdata SHALL then be 0.
REQ-027 SHALL, on a simultaneous push and pop in one cycle, update fifo_count by net 0 and preserve FIFO order.
REQ-028 SHALL treat a push into an empty FIFO as not poppable in the same cycle; the earliest write of that entry is cycle N+2.
REQ-029 SHALL drain FIFO entries strictly in arrival order, and SHALL never issue two register writes in one cycle.
REQ-030 SHALL let read and write pointers wrap modulo FIFO_DEPTH, with fifo_count distinguishing full from empty.
REQ-031 SHALL make no ordering check between sources; if both target the same register in one cycle, the primary write occurs first and the secondary write later, so the secondary value prevails.

Reset
REQ-032 SHALL, while rst=1, hold we=0, waddr=0, wdata=0, fifo_count=0, sec_ready=0, with both pointers at 0.
REQ-033 SHALL discard all buffered entries and in-flight requests on assertion of rst mid-operation; no write SHALL issue after reset deassertion for a request made before it.
REQ-034 SHALL drive sec_ready=1 in the first clock edge after rst deasserts.

Verification
REQ-035 SHALL be covered by: primary mem_wreg=1, mem_wd=5, mem_wdata=0xDEADBEEF, stall=0 -> next cycle we=1, waddr=5, wdata=0xDEADBEEF.
REQ-036 SHALL be covered by: primary with mem_wd=0, or with stall[4]=1 -> next cycle we=0, waddr=0, wdata=0.
REQ-037 SHALL be covered by: primary writes on 4 consecutive cycles while secondary pushes x7=0x11 then x8=0x22 -> sec_ready=0 once fifo_count=2, both entries write in order x7 then x8 immediately after the primary burst ends.
REQ-038 SHALL be covered by: same cycle primary x3=0xA and secondary x3=0xB into an empty FIFO -> x3=0xA written at N+1 and x3=0xB at N+2.
REQ-039 SHALL be covered by: secondary push with sec_wd=0 -> handshake completes, fifo_count unchanged, no write.
REQ-040 SHALL be covered by: rst asserted with fifo_count=2 -> all outputs 0 immediately; after deassertion no buffered write appears and sec_ready=1.
